// File: rtl/main_memory_word_packer_pkg.sv
// main_memory_word_packer_pkg: capture-mode encodings, FSM states and counter width shared by the packer.
package main_memory_word_packer_pkg;
  localparam logic [2:0] MODE_SINGLE = 3'b000;
  localparam logic [2:0] MODE_DUAL = 3'b001;
  localparam logic [2:0] MODE_OCTAL = 3'b011;
  localparam int WORD_CNT_W = 24;
  typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_ERR} state_t;
  function automatic logic mode_legal(input logic [2:0] m);
    return m == MODE_SINGLE || m == MODE_DUAL || m == MODE_OCTAL;
  endfunction
endpackage

// File: rtl/main_memory_word_packer_lane_mask.sv
// main_memory_lane_mask: zeroes lane bits at and above the active ADC resolution (clamped to 8..W).
module main_memory_lane_mask #(
  parameter int W = 16
) (
  input  logic [W-1:0] d,
  input  logic [4:0]   res,
  output logic [W-1:0] q
);
  localparam logic [4:0] MAX_RES = 5'(W);
  logic [4:0] r;
  always_comb begin
    r = res > MAX_RES ? MAX_RES : res < 5'd8 ? 5'd8 : res;
    q = d & ~({W{1'b1}} << r);
  end
endmodule

// File: rtl/main_memory_word_packer.sv
// main_memory_word_packer: packs masked ADC samples into BRAM/SRAM words ordered by capture mode.
module main_memory_word_packer
  import main_memory_word_packer_pkg::*;
#(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM = 8,
  parameter int SRAM_WORD_NUM = 4,
  parameter int ADC_CH_NUM = 8
) (
  input  logic                                   i_word_packer_clk,
  input  logic                                   i_word_packer_reset_n,
  input  logic [ADC_MAX_DATA_SIZE*ADC_CH_NUM-1:0]    i_word_packer_adc_data,
  input  logic                                   i_word_packer_adc_valid,
  input  logic [4:0]                             i_word_packer_adc_res,
  input  logic [2:0]                             i_word_packer_capture_mode,
  input  logic                                   i_word_packer_en,
  output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] o_word_packer_bram_data,
  output logic                                   o_word_packer_bram_wr_en,
  output logic [ADC_MAX_DATA_SIZE*SRAM_WORD_NUM-1:0] o_word_packer_sram_data,
  output logic                                   o_word_packer_sram_wr_en,
  output logic [WORD_CNT_W-1:0]                  o_word_packer_word_cnt,
  output logic                                   o_word_packer_mode_err
);
  localparam int W = ADC_MAX_DATA_SIZE;
  state_t state;
  logic en_q, accept, octal, dual;
  logic [2:0] mode, cnt, last;
  logic [W-1:0] ch [ADC_CH_NUM];
  logic [W-1:0] lanes [BRAM_WORD_NUM];
  logic [W-1:0] nl [BRAM_WORD_NUM];
  logic [W*BRAM_WORD_NUM-1:0] bram_next;
  logic [W*SRAM_WORD_NUM-1:0] sram_next;
  for (genvar g = 0; g < ADC_CH_NUM; g++) begin : g_mask
    main_memory_lane_mask #(.W(W)) u_mask (
      .d  (i_word_packer_adc_data[g*W +: W]),
      .res(i_word_packer_adc_res),
      .q  (ch[g])
    );
  end
  // last is the highest lane written by this valid; a word completes when it is lane 7
  always_comb begin
    octal = mode == MODE_OCTAL;
    dual = mode == MODE_DUAL;
    accept = state == ST_PACK && i_word_packer_en && en_q && i_word_packer_adc_valid;
    last = octal ? 3'd7 : dual ? 3'(cnt + 3'd1) : cnt;
    nl = lanes;
    if (octal) for (int i = 0; i < BRAM_WORD_NUM; i++) nl[i] = ch[i];
    else begin
      nl[cnt] = ch[0];
      if (dual) nl[last] = ch[1];
    end
    for (int i = 0; i < BRAM_WORD_NUM; i++) bram_next[i*W +: W] = nl[i];
    for (int i = 0; i < SRAM_WORD_NUM; i++) sram_next[i*W +: W] = nl[{last[2], 2'(i)}];
  end
  always_ff @(posedge i_word_packer_clk)
    if (accept) lanes <= nl;
  always_ff @(posedge i_word_packer_clk or negedge i_word_packer_reset_n)
    if (!i_word_packer_reset_n) begin
      state <= ST_IDLE;
      en_q <= 1'b0;
      mode <= MODE_SINGLE;
      cnt <= '0;
      o_word_packer_bram_data <= '0;
      o_word_packer_bram_wr_en <= 1'b0;
      o_word_packer_sram_data <= '0;
      o_word_packer_sram_wr_en <= 1'b0;
      o_word_packer_word_cnt <= '0;
      o_word_packer_mode_err <= 1'b0;
    end else begin
      en_q <= i_word_packer_en;
      o_word_packer_bram_wr_en <= 1'b0;
      o_word_packer_sram_wr_en <= 1'b0;
      if (!i_word_packer_en) begin
        state <= ST_IDLE;
        cnt <= '0;
      end else if (!en_q) begin
        mode <= i_word_packer_capture_mode;
        cnt <= '0;
        o_word_packer_word_cnt <= '0;
        state <= mode_legal(i_word_packer_capture_mode) ? ST_PACK : ST_ERR;
        o_word_packer_mode_err <= !mode_legal(i_word_packer_capture_mode);
      end else if (accept) begin
        cnt <= 3'(last + 3'd1);
        if (&last) begin
          o_word_packer_bram_data <= bram_next;
          o_word_packer_bram_wr_en <= 1'b1;
          if (!(&o_word_packer_word_cnt)) o_word_packer_word_cnt <= o_word_packer_word_cnt + 1'b1;
        end
        if (!octal && &last[1:0]) begin
          o_word_packer_sram_data <= sram_next;
          o_word_packer_sram_wr_en <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_main_memory_word_packer.sv
// tb_main_memory_word_packer: sample-queue reference model plus directed literal checks and random traffic.
module tb_main_memory_word_packer;
  logic clk = 0, rst_n = 0;
  logic [127:0] adc_data = '0;
  logic adc_valid = 0;
  logic [4:0] adc_res = 5'd16;
  logic [2:0] cmode = 3'd0;
  logic en = 0;
  logic [127:0] bram_data;
  logic bram_wr_en;
  logic [63:0] sram_data;
  logic sram_wr_en;
  logic [23:0] word_cnt;
  logic mode_err;
  int checks = 0, errors = 0, bram_pulses = 0;
  logic [63:0] sq[$];
  always #5 clk = ~clk;
  main_memory_word_packer dut (
    .i_word_packer_clk(clk), .i_word_packer_reset_n(rst_n),
    .i_word_packer_adc_data(adc_data), .i_word_packer_adc_valid(adc_valid),
    .i_word_packer_adc_res(adc_res), .i_word_packer_capture_mode(cmode),
    .i_word_packer_en(en), .o_word_packer_bram_data(bram_data),
    .o_word_packer_bram_wr_en(bram_wr_en), .o_word_packer_sram_data(sram_data),
    .o_word_packer_sram_wr_en(sram_wr_en), .o_word_packer_word_cnt(word_cnt),
    .o_word_packer_mode_err(mode_err)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] msk(input logic [15:0] v, input int res);
    int r;
    r = res > 16 ? 16 : (res < 8 ? 8 : res);
    return 16'(int'(v) & ((1 << r) - 1));
  endfunction
  function automatic bit legal(input logic [2:0] m);
    return m == 3'd0 || m == 3'd1 || m == 3'd3;
  endfunction
  // reference: accepted samples queue up in arrival order; every 4 form an SRAM word, every 8 a BRAM word
  logic [15:0] q[$];
  bit cap = 0, pen = 0;
  logic [2:0] md = 0;
  int n;
  logic [127:0] e_bd = 0;
  logic [63:0] e_sd = 0;
  logic e_bw = 0, e_sw = 0, e_err = 0;
  logic [23:0] e_wc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); cap = 0; pen = 0; md = 0;
      e_bd = 0; e_sd = 0; e_bw = 0; e_sw = 0; e_err = 0; e_wc = 0;
    end else begin
      e_bw = 0; e_sw = 0;
      if (!en) begin
        cap = 0; q.delete();
      end else if (!pen) begin
        e_wc = 0; q.delete(); md = cmode;
        cap = legal(cmode); e_err = !legal(cmode);
      end else if (cap && adc_valid) begin
        n = md == 3 ? 8 : (md == 1 ? 2 : 1);
        for (int k = 0; k < n; k++) q.push_back(msk(adc_data[k*16 +: 16], int'(adc_res)));
        if (md != 3 && q.size() % 4 == 0) begin
          e_sw = 1;
          for (int k = 0; k < 4; k++) e_sd[k*16 +: 16] = q[q.size() - 4 + k];
        end
        if (q.size() == 8) begin
          e_bw = 1;
          for (int k = 0; k < 8; k++) e_bd[k*16 +: 16] = q[k];
          if (e_wc != 24'hFFFFFF) e_wc = e_wc + 1;
          q.delete();
        end
      end
      pen = en;
    end
  end
  always @(negedge clk) begin
    chk("bram_wr_en", 128'(bram_wr_en), 128'(e_bw));
    chk("bram_data", bram_data, e_bd);
    chk("sram_wr_en", 128'(sram_wr_en), 128'(e_sw));
    chk("sram_data", 128'(sram_data), 128'(e_sd));
    chk("word_cnt", 128'(word_cnt), 128'(e_wc));
    chk("mode_err", 128'(mode_err), 128'(e_err));
  end
  always @(negedge clk) begin
    if (bram_wr_en) bram_pulses++;
    if (sram_wr_en) sq.push_back(sram_data);
  end
  task automatic drive(input logic v, input logic [127:0] d);
    @(negedge clk); adc_valid = v; adc_data = d;
  endtask
  task automatic restart(input logic [2:0] m);
    @(negedge clk); en = 0; adc_valid = 0;
    @(negedge clk); cmode = m; en = 1;
  endtask
  task automatic settle;
    drive(0, '0); #1;
  endtask
  task automatic mark;
    bram_pulses = 0; sq.delete();
  endtask
  logic [127:0] pat;
  int r, m;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bram", bram_data, '0);
    chk("reset_cnt", 128'(word_cnt), '0);
    rst_n = 1;
    mark; restart(3'd0);
    for (int i = 1; i <= 8; i++) drive(1, 128'(i));
    settle;
    chk("t1_bram_en", 128'(bram_wr_en), 128'd1);
    chk("t1_bram", bram_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_sram_n", 128'(sq.size()), 128'd2);
    chk("t1_sram0", 128'(sq[0]), 128'h0004_0003_0002_0001);
    chk("t1_sram1", 128'(sq[1]), 128'h0008_0007_0006_0005);
    chk("t1_wcnt", 128'(word_cnt), 128'd1);
    mark; restart(3'd1);
    for (int i = 0; i < 4; i++) drive(1, 128'(((11 + 2 * i) << 16) | (10 + 2 * i)));
    #1 chk("t2_not_early", 128'(bram_wr_en), 128'd0);
    settle;
    chk("t2_bram_en", 128'(bram_wr_en), 128'd1);
    chk("t2_bram", bram_data, 128'h0011_0010_000f_000e_000d_000c_000b_000a);
    settle;
    chk("t2_one_cycle", 128'(bram_wr_en), 128'd0);
    chk("t2_pulses", 128'(bram_pulses), 128'd1);
    chk("t2_sram1", 128'(sq[1]), 128'h0011_0010_000f_000e);
    mark; restart(3'd3);
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 8; k++) pat[k*16 +: 16] = 16'(16'h0100 * (v + 1) + k);
      drive(1, pat);
    end
    settle; settle;
    chk("t3_pulses", 128'(bram_pulses), 128'd3);
    chk("t3_no_sram", 128'(sq.size()), 128'd0);
    chk("t3_wcnt", 128'(word_cnt), 128'd3);
    chk("t3_bram", bram_data, 128'h0307_0306_0305_0304_0303_0302_0301_0300);
    mark; adc_res = 5'd12; restart(3'd0);
    for (int i = 0; i < 8; i++) drive(1, {128{1'b1}});
    settle;
    chk("t4_mask", bram_data, 128'h0fff_0fff_0fff_0fff_0fff_0fff_0fff_0fff);
    adc_res = 5'd16;
    mark; restart(3'd0);
    for (int i = 0; i < 8; i++) drive(1, 128'(90 + i));
    for (int i = 0; i < 5; i++) drive(1, 128'(100 + i));
    restart(3'd0);
    settle;
    chk("t5_wcnt_clr", 128'(word_cnt), 128'd0);
    for (int i = 0; i < 8; i++) drive(1, 128'(200 + i));
    settle;
    chk("t5_pulses", 128'(bram_pulses), 128'd2);
    chk("t5_bram", bram_data, 128'h00cf_00ce_00cd_00cc_00cb_00ca_00c9_00c8);
    chk("t5_wcnt", 128'(word_cnt), 128'd1);
    mark; restart(3'd4);
    settle;
    chk("t6_err", 128'(mode_err), 128'd1);
    for (int i = 0; i < 8; i++) drive(1, {$urandom, $urandom, $urandom, $urandom});
    settle;
    chk("t6_no_bram", 128'(bram_pulses), 128'd0);
    chk("t6_no_sram", 128'(sq.size()), 128'd0);
    restart(3'd0);
    settle;
    chk("t6_err_clr", 128'(mode_err), 128'd0);
    for (int i = 0; i < 3; i++) drive(1, 128'(i + 1));
    #2 rst_n = 0;
    #1;
    chk("t6_rst_bram", bram_data, '0);
    chk("t6_rst_cnt", 128'(word_cnt), '0);
    chk("t6_rst_en", 128'({bram_wr_en, sram_wr_en, mode_err}), '0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 8; i++) drive(1, 128'(16'h50 + i));
    settle;
    chk("t6_after_rst", bram_data, 128'h0057_0056_0055_0054_0053_0052_0051_0050);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        en = ~en;
        m = $urandom_range(0, 4);
        cmode = m == 0 ? 3'd0 : m == 1 ? 3'd1 : m == 2 ? 3'd3 : m == 3 ? 3'd3 : 3'($urandom_range(4, 7));
      end else if (r == 50) cmode = 3'($urandom_range(0, 7));
      if (r > 95) adc_res = 5'($urandom_range(0, 31));
      adc_valid = $urandom_range(0, 9) < 7;
      adc_data = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
